lamp_sqrt_issuer: RTL and testbench

- Front-end initiator for the floating-point square-root / inverse-square-root unit.
- Accepts a packed LAMP float (1 sign, 8 exponent, 7 fraction, bias 127) over a valid/ready handshake.
- Resolves special operands locally; otherwise unpacks to sign / unbiased signed exponent / mantissa with hidden bit, pulses DoSqrt or DoInvSqrt, and waits for the unit's valid.
- Repacks the unit's result and returns it over a second valid/ready handshake. Includes a watchdog against a non-responding unit.

---
 rtl/lamp_sqrt_issuer.sv | 186 ++++++++++++++++++
 tb/tb_lamp_sqrt_issuer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_sqrt_issuer.sv
// Issue stage for the LAMP sqrt / inverse-sqrt unit: special-case filtering,
// operand unpacking, start pulse, result repacking and watchdog abort.
module lamp_sqrt_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter logic [15:0] QNAN           = 16'h7FC0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [15:0] op_a_i,
    input  logic        op_inv_i,
    output logic        sq_DoSqrt_o,
    output logic        sq_DoInvSqrt_o,
    output logic        sq_s_o,
    output logic [7:0]  sq_e_o,
    output logic [7:0]  sq_m_o,
    input  logic        sq_s_i,
    input  logic [7:0]  sq_e_i,
    input  logic [7:0]  sq_m_i,
    input  logic        sq_valid_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [15:0] res_o,
    output logic        res_invalid_o,
    output logic        res_err_o
);

    localparam int unsigned   WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              do_sqrt_q, do_sqrt_d;
    logic              do_inv_q, do_inv_d;
    logic              sq_s_q, sq_s_d;
    logic [7:0]        sq_e_q, sq_e_d;
    logic [7:0]        sq_m_q, sq_m_d;
    logic              res_valid_q, res_valid_d;
    logic [15:0]       res_q, res_d;
    logic              invalid_q, invalid_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              op_s;
    logic [7:0]        op_e;
    logic [6:0]        op_f;
    logic signed [9:0] pack_b;
    logic [15:0]       pack_res;
    logic [WD_W-1:0]   wd_inc;

    assign op_s = op_a_i[15];
    assign op_e = op_a_i[14:7];
    assign op_f = op_a_i[6:0];

    assign op_ready_o     = (state_q == IDLE);
    assign sq_DoSqrt_o    = do_sqrt_q;
    assign sq_DoInvSqrt_o = do_inv_q;
    assign sq_s_o         = sq_s_q;
    assign sq_e_o         = sq_e_q;
    assign sq_m_o         = sq_m_q;
    assign res_valid_o    = res_valid_q;
    assign res_o          = res_q;
    assign res_invalid_o  = invalid_q;
    assign res_err_o      = err_q;

    // Rebias in 10 bits so under/overflow of the biased exponent is visible.
    always_comb begin
        pack_b = $signed({{2{sq_e_i[7]}}, sq_e_i}) + 10'sd127;
        if (sq_m_i == 8'h00 || pack_b <= 10'sd0) begin
            pack_res = {sq_s_i, 15'h0000};
        end else if (pack_b >= 10'sd255) begin
            pack_res = {sq_s_i, 8'hFF, 7'h00};
        end else begin
            pack_res = {sq_s_i, pack_b[7:0], sq_m_i[6:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        do_sqrt_d   = 1'b0;
        do_inv_d    = 1'b0;
        sq_s_d      = sq_s_q;
        sq_e_d      = sq_e_q;
        sq_m_d      = sq_m_q;
        res_valid_d = res_valid_q;
        res_d       = res_q;
        invalid_d   = invalid_q;
        err_d       = err_q;
        wd_d        = wd_q;
        wd_inc      = wd_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    invalid_d = 1'b0;
                    err_d     = 1'b0;
                    if ((op_e == 8'hFF && op_f != 7'h00) ||
                        (op_s && (op_e != 8'h00 || op_f != 7'h00))) begin
                        res_d       = QNAN;
                        invalid_d   = 1'b1;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (op_e == 8'h00) begin
                        res_d       = op_inv_i ? {op_s, 8'hFF, 7'h00} : {op_s, 15'h0000};
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (op_e == 8'hFF) begin
                        res_d       = op_inv_i ? 16'h0000 : 16'h7F80;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        sq_s_d    = op_s;
                        sq_e_d    = op_e - 8'd127;
                        sq_m_d    = {1'b1, op_f};
                        do_sqrt_d = ~op_inv_i;
                        do_inv_d  = op_inv_i;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_inc;
                if (sq_valid_i) begin
                    res_d       = pack_res;
                    invalid_d   = 1'b0;
                    err_d       = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (wd_inc == WD_LAST) begin
                    res_d       = QNAN;
                    invalid_d   = 1'b0;
                    err_d       = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            do_sqrt_q   <= 1'b0;
            do_inv_q    <= 1'b0;
            sq_s_q      <= 1'b0;
            sq_e_q      <= '0;
            sq_m_q      <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            invalid_q   <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            do_sqrt_q   <= do_sqrt_d;
            do_inv_q    <= do_inv_d;
            sq_s_q      <= sq_s_d;
            sq_e_q      <= sq_e_d;
            sq_m_q      <= sq_m_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            invalid_q   <= invalid_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

endmodule

// File: tb/tb_lamp_sqrt_issuer.sv
// Scoreboard bench for lamp_sqrt_issuer: specials, normal issue/repack,
// watchdog abort, consumer backpressure and mid-operation reset.
module tb_lamp_sqrt_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic [15:0] op_a_i = '0;
    logic        op_inv_i = 1'b0;
    logic        sq_DoSqrt_o, sq_DoInvSqrt_o, sq_s_o;
    logic [7:0]  sq_e_o, sq_m_o;
    logic        sq_s_i = 1'b0;
    logic [7:0]  sq_e_i = '0;
    logic [7:0]  sq_m_i = '0;
    logic        sq_valid_i = 1'b0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [15:0] res_o;
    logic        res_invalid_o, res_err_o;

    typedef struct packed {
        logic [15:0] res;
        logic        inv;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    lamp_sqrt_issuer #(.TIMEOUT_CYCLES(32), .QNAN(16'h7FC0)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid_i    (op_valid_i),
        .op_ready_o    (op_ready_o),
        .op_a_i        (op_a_i),
        .op_inv_i      (op_inv_i),
        .sq_DoSqrt_o   (sq_DoSqrt_o),
        .sq_DoInvSqrt_o(sq_DoInvSqrt_o),
        .sq_s_o        (sq_s_o),
        .sq_e_o        (sq_e_o),
        .sq_m_o        (sq_m_o),
        .sq_s_i        (sq_s_i),
        .sq_e_i        (sq_e_i),
        .sq_m_i        (sq_m_i),
        .sq_valid_i    (sq_valid_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_o         (res_o),
        .res_invalid_o (res_invalid_o),
        .res_err_o     (res_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and return once it has been accepted.
    task automatic send(input string tag, input logic [15:0] a, input logic inv);
        int n = 0;
        while (!op_ready_o && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {31'd0, op_ready_o}, 32'd1);
        op_valid_i = 1'b1;
        op_a_i     = a;
        op_inv_i   = inv;
        tick();
        op_valid_i = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   n = 0;
        exp_t e;
        while (!res_valid_o && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, res_valid_o}, 32'd1);
        check({tag, "_sb"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_res"}, {16'd0, res_o}, {16'd0, e.res});
            check({tag, "_flags"}, {30'd0, res_invalid_o, res_err_o}, {30'd0, e.inv, e.err});
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check({tag, "_rdy_after"}, {31'd0, op_ready_o}, 32'd1);
    endtask

    task automatic run_special(input string tag, input logic [15:0] a, input logic inv,
                               input logic [15:0] exp_res, input logic exp_inv);
        send(tag, a, inv);
        sb.push_back('{res: exp_res, inv: exp_inv, err: 1'b0});
        check({tag, "_nopulse"}, {30'd0, sq_DoSqrt_o, sq_DoInvSqrt_o}, 32'd0);
        check({tag, "_lat1"}, {31'd0, res_valid_o}, 32'd1);
        collect(tag);
    endtask

    // Normal path: verify issue cycle, then respond after lat cycles.
    task automatic run_normal(input string tag, input logic [15:0] a, input logic inv,
                              input logic [7:0] exp_e, input logic [7:0] exp_m,
                              input logic u_s, input logic [7:0] u_e, input logic [7:0] u_m,
                              input int lat, input logic [15:0] exp_res);
        send(tag, a, inv);
        sb.push_back('{res: exp_res, inv: 1'b0, err: 1'b0});
        check({tag, "_pulse"}, {30'd0, sq_DoSqrt_o, sq_DoInvSqrt_o}, {30'd0, ~inv, inv});
        check({tag, "_opnd"}, {15'd0, sq_s_o, sq_e_o, sq_m_o}, {15'd0, a[15], exp_e, exp_m});
        tick();
        check({tag, "_pulse_off"}, {30'd0, sq_DoSqrt_o, sq_DoInvSqrt_o}, 32'd0);
        for (int i = 1; i < lat; i++) tick();
        check({tag, "_stable"}, {16'd0, sq_e_o, sq_m_o}, {16'd0, exp_e, exp_m});
        sq_valid_i = 1'b1;
        sq_s_i     = u_s;
        sq_e_i     = u_e;
        sq_m_i     = u_m;
        tick();
        sq_valid_i = 1'b0;
        check({tag, "_lat"}, {31'd0, res_valid_o}, 32'd1);
        collect(tag);
    endtask

    initial begin
        logic        seen;
        logic [15:0] held;

        repeat (3) tick();
        check("reset_outs", {sq_DoSqrt_o, sq_DoInvSqrt_o, sq_s_o, sq_e_o, sq_m_o, res_valid_o,
                             res_invalid_o, res_err_o, 8'd0}, 32'd0);
        check("reset_res", {16'd0, res_o}, 32'd0);
        check("reset_ready", {31'd0, op_ready_o}, 32'd1);
        rst = 1'b1;
        tick();

        run_normal("sqrt4", 16'h4080, 1'b0, 8'h02, 8'h80, 1'b0, 8'h01, 8'h80, 1, 16'h4000);
        run_normal("isqrt4", 16'h4080, 1'b1, 8'h02, 8'h80, 1'b0, 8'hFF, 8'h80, 3, 16'h3F00);
        run_normal("frac", 16'h3E40, 1'b0, 8'hFD, 8'hC0, 1'b0, 8'h7F, 8'hC5, 2, 16'h7F45);
        run_normal("uflow0", 16'h3F80, 1'b0, 8'h00, 8'h80, 1'b0, 8'h81, 8'h80, 1, 16'h0000);
        run_normal("minnorm", 16'h3F80, 1'b1, 8'h00, 8'h80, 1'b0, 8'h82, 8'h80, 1, 16'h0080);
        run_normal("mzero", 16'h3F80, 1'b0, 8'h00, 8'h80, 1'b1, 8'h00, 8'h00, 4, 16'h8000);

        run_special("neg", 16'hC080, 1'b0, 16'h7FC0, 1'b1);
        run_special("mzero_sq", 16'h8000, 1'b0, 16'h8000, 1'b0);
        run_special("zero_inv", 16'h0000, 1'b1, 16'h7F80, 1'b0);
        run_special("mzero_inv", 16'h8000, 1'b1, 16'hFF80, 1'b0);
        run_special("inf_inv", 16'h7F80, 1'b1, 16'h0000, 1'b0);
        run_special("inf_sq", 16'h7F80, 1'b0, 16'h7F80, 1'b0);
        run_special("nan", 16'h7FC1, 1'b0, 16'h7FC0, 1'b1);
        run_special("denorm", 16'h0001, 1'b0, 16'h0000, 1'b0);
        run_special("ndenorm", 16'h8001, 1'b1, 16'h7FC0, 1'b1);
        run_special("ninf", 16'hFF80, 1'b0, 16'h7FC0, 1'b1);

        // Watchdog: no response, DONE exactly 32 cycles after ISSUE.
        send("tmo", 16'h4080, 1'b0);
        sb.push_back('{res: 16'h7FC0, inv: 1'b0, err: 1'b1});
        seen = 1'b0;
        for (int i = 1; i < 32; i++) begin
            tick();
            seen = seen | res_valid_o;
        end
        check("tmo_early", {31'd0, seen}, 32'd0);
        tick();
        check("tmo_at32", {31'd0, res_valid_o}, 32'd1);
        collect("tmo");
        sq_valid_i = 1'b1;
        tick();
        sq_valid_i = 1'b0;
        tick();
        check("tmo_stray", {31'd0, res_valid_o}, 32'd0);

        // Backpressure, then back-to-back acceptance.
        send("bp", 16'hC080, 1'b0);
        sb.push_back('{res: 16'h7FC0, inv: 1'b1, err: 1'b0});
        held = res_o;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | op_ready_o | ~res_valid_o | (res_o != held);
        end
        check("bp_hold", {31'd0, seen}, 32'd0);
        collect("bp");
        run_special("b2b", 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Reset while waiting for the unit.
        send("rstw", 16'h4080, 1'b1);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("rstw_outs", {sq_DoSqrt_o, sq_DoInvSqrt_o, sq_s_o, sq_e_o, sq_m_o, res_valid_o,
                            res_invalid_o, res_err_o, 8'd0}, 32'd0);
        check("rstw_res", {16'd0, res_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        check("rstw_ready", {31'd0, op_ready_o}, 32'd1);
        sq_valid_i = 1'b1;
        sq_e_i     = 8'h01;
        sq_m_i     = 8'h80;
        tick();
        sq_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | res_valid_o;
        end
        check("rstw_late", {31'd0, seen}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
